ssf_blackbox: RTL and testbench

Streaming scalar iterative-shrinkage (SSF-style) denoiser for signed 32-bit samples. It pulls one sample at a time from an upstream source through a request strobe. It runs a fixed number of shrinkage iterations on each sample and pushes the estimate downstream with an output-enable strobe. It sits between a sample file or ADC reader and a result sink.

---
 rtl/ssf_blackbox.sv | 99 +++++++++
 tb/tb_ssf_blackbox.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ssf_blackbox.sv
// Streaming scalar iterative soft-threshold denoiser.
// Pulls a sample, runs ITER shrinkage steps, pushes the estimate.
module ssf_blackbox #(
  parameter int ITER   = 4,
  parameter int MU_SH  = 1,
  parameter int LAMBDA = 8
) (
  input  logic               clk,
  input  logic signed [31:0] in,
  output logic signed [31:0] io_out,
  output logic [1:0]         req_in,
  output logic [1:0]         out_en,
  input  logic               rst_n
);

  localparam int KW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(ITER - 1);
  localparam logic signed [33:0] LAM  = 34'(LAMBDA);
  localparam logic signed [33:0] SMAX = 34'sh0_7FFF_FFFF;
  localparam logic signed [33:0] SMIN = -34'sh0_8000_0000;

  typedef enum logic [1:0] {INIT, REQ, RUN, OUT} state_e;

  state_e             state_q, state_d;
  logic signed [31:0] x_q, x_d;
  logic signed [31:0] y_q, y_d;
  logic signed [31:0] out_q, out_d;
  logic [KW-1:0]      k_q, k_d;

  logic signed [33:0] xe, ye, df, v, s;
  logic signed [31:0] x_nxt;

  // One shrinkage step in 34-bit arithmetic, saturated back to 32 bits
  always_comb begin
    xe = {{2{x_q[31]}}, x_q};
    ye = {{2{y_q[31]}}, y_q};
    df = ye - xe;
    v  = xe + (df >>> MU_SH);
    s  = '0;
    if (v > LAM)
      s = v - LAM;
    else if (v < -LAM)
      s = v + LAM;
    if (s > SMAX)
      x_nxt = 32'sh7FFF_FFFF;
    else if (s < SMIN)
      x_nxt = -32'sh7FFF_FFFF - 32'sd1;
    else
      x_nxt = s[31:0];
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    out_d   = out_q;
    unique case (state_q)
      INIT: state_d = REQ;
      REQ: begin
        y_d     = in;
        x_d     = '0;
        k_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        x_d = x_nxt;
        k_d = k_q + KW'(1);
        if (k_q == K_LAST) begin
          out_d   = x_nxt;
          state_d = OUT;
        end
      end
      OUT: state_d = REQ;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      out_q   <= out_d;
    end
  end

  assign io_out = out_q;
  assign req_in = {1'b0, state_q == REQ};
  assign out_en = {1'b0, state_q == OUT};

endmodule

// File: tb/tb_ssf_blackbox.sv
// Bench for ssf_blackbox: vector table streamed through a
// scoreboard, plus reset and mid-run reset sequences.
module tb_ssf_blackbox;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [31:0] in;
  logic signed [31:0] io_out;
  logic [1:0]         req_in;
  logic [1:0]         out_en;

  ssf_blackbox dut (
    .clk    (clk),
    .in     (in),
    .io_out (io_out),
    .req_in (req_in),
    .out_en (out_en),
    .rst_n  (rst_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] y;
    logic signed [31:0] exp;
  } vec_t;

  typedef struct {
    logic signed [31:0] exp;
    int                 cyc;
  } sb_t;

  int errors = 0;
  int checks = 0;
  sb_t sbq[$];
  logic signed [31:0] cur_exp;
  logic signed [31:0] last_out;
  bit mon_en = 0;
  int cyc = 0;
  int last_req = -1;

  // Independent reference: 64-bit arithmetic with explicit clamping
  function automatic logic signed [31:0] ref_model(input longint y);
    longint x, v, s;
    x = 0;
    for (int i = 0; i < 4; i++) begin
      v = x + ((y - x) >>> 1);
      if (v > 8) s = v - 8;
      else if (v < -8) s = v + 8;
      else s = 0;
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
      x = s;
    end
    return 32'(x);
  endfunction

  task automatic chk(input string name, input longint act,
                     input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (!rst_n) begin
        sbq.delete();
        last_req = -1;
        last_out = '0;
      end else begin
        chk("strobe_bits", {req_in[1], out_en[1],
            req_in[0] & out_en[0]}, 0);
        if (req_in == 2'b01) begin
          if (last_req >= 0)
            chk("req_period", cyc - last_req, 6);
          last_req = cyc;
          sbq.push_back('{exp: cur_exp, cyc: cyc});
        end
        if (out_en == 2'b01) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: io_out=%0d, none expected",
                     io_out);
          end else begin
            sb_t e;
            e = sbq.pop_front();
            chk("io_out", io_out, e.exp);
            chk("latency", cyc - e.cyc, 5);
          end
          last_out = io_out;
        end else begin
          chk("io_out_hold", io_out, last_out);
        end
      end
    end
  end

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (req_in != 2'b01 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_in != 2'b01) chk(name, req_in, 2'b01);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{y: 100,  exp: 78};
    vecs[1]  = '{y: -100, exp: -79};
    vecs[2]  = '{y: 10,   exp: 0};
    vecs[3]  = '{y: 100,  exp: 78};
    vecs[4]  = '{y: 0,    exp: 0};
    vecs[5]  = '{y: -10,  exp: 0};
    vecs[6]  = '{y: 20,   exp: 3};
    vecs[7]  = '{y: -20,  exp: -4};
    vecs[8]  = '{y: 32'sh7FFF_FFFF, exp: ref_model(64'sd2147483647)};
    vecs[9]  = '{y: -32'sh7FFF_FFFF - 1,
                 exp: ref_model(-64'sd2147483648)};
    vecs[10] = '{y: 100,  exp: 78};

    rst_n   = 1'b0;
    in      = vecs[0].y;
    cur_exp = vecs[0].exp;
    last_out = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req", req_in, 0);
      chk("rst_out_en", out_en, 0);
      chk("rst_io_out", io_out, 0);
    end
    mon_en = 1;
    rst_n  = 1'b1;
    @(negedge clk);
    chk("startup_req", req_in, 2'b01);

    for (int i = 0; i < 11; i++) begin
      in      = vecs[i].y;
      cur_exp = vecs[i].exp;
      wait_req("stream_req_timeout");
      @(posedge clk);
      #1;
    end
    drain();

    in      = 32'sd100;
    cur_exp = 32'sd78;
    wait_req("abort_req_timeout");
    @(posedge clk);
    #1;
    in      = -32'sd100;
    cur_exp = -32'sd79;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_out_en", out_en, 0);
    chk("abort_io_out", io_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_req", req_in, 2'b01);
    @(posedge clk);
    #1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
